// File: rtl/m_lsu.sv
// Memory-stage load/store unit: initiator side of the data-memory interface.
// Checks alignment and issues one word-aligned request with byte enables per
// instruction. Stalls the pipeline until the memory acknowledges or the
// request times out. Returns sign- or zero-extended load data.
module m_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        flush,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } op_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state, state_nxt;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] cnt;

  logic        is_load, is_store, misal;
  logic        req_ok, accept, timeout;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_val;

  // pc only feeds the simulation trace, which lives outside this block
  logic unused_pc;
  assign unused_pc = ^pc;

  // Decode the incoming op: class and alignment check
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misal    = 1'b0;
    case (op)
      OP_LW:         begin is_load  = 1'b1; misal = |addr[1:0]; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; misal = addr[0];    end
      OP_LB, OP_LBU: begin is_load  = 1'b1;                     end
      OP_SW:         begin is_store = 1'b1; misal = |addr[1:0]; end
      OP_SH:         begin is_store = 1'b1; misal = addr[0];    end
      OP_SB:         begin is_store = 1'b1;                     end
      default:       ;
    endcase
  end

  assign req_ok  = (state == IDLE) && valid && !flush;
  assign accept  = req_ok && (is_load || is_store) && !misal;
  assign timeout = (state == REQ) && !mem_ack && (cnt == CNT_LAST);

  // Byte enables and lane-replicated store data for the incoming op
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = '0;
    case (op)
      OP_SW: wdata_nxt = wdata;
      OP_SH: begin
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{wdata[15:0]}};
      end
      OP_SB: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension of the returned word using the registered offset
  always_comb begin
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    case (op_q)
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'h0000, half_sel};
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ: begin
        if (mem_ack)      state_nxt = DONE;
        else if (timeout) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: stall, completion and alignment exceptions
  always_comb begin
    stall    = 1'b0;
    done     = 1'b0;
    exc_adel = 1'b0;
    exc_ades = 1'b0;
    case (state)
      IDLE: begin
        stall    = accept;
        exc_adel = req_ok && is_load  && misal;
        exc_ades = req_ok && is_store && misal;
      end
      REQ:     stall = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // Request fields, timeout counter, load result and bus error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      op_q      <= '0;
      off_q     <= '0;
      cnt       <= '0;
      rdata     <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_nxt;
            mem_wdata <= wdata_nxt;
            op_q      <= op;
            off_q     <= addr[1:0];
            cnt       <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata <= load_val;
          end else if (timeout) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
